// File: rtl/spi_flash_sequencer_if.sv
// Signal bundle between the two word requesters, the byte-level SPI shift
// engine and the flash transaction sequencer.
//
// Handshakes:
//   - req0/req1 are held high by a port until its one-cycle ack0/ack1 pulse;
//     rdata and err are valid in the ack cycle (rdata holds until the next ack).
//   - shift_start is a one-cycle pulse with shift_tx valid in that cycle; the
//     engine answers with a one-cycle shift_done pulse carrying shift_rx. Only
//     one byte is ever outstanding.
interface spi_flash_sequencer_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [23:0] addr0;
    logic [23:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic        cs_n;
    logic        shift_start;
    logic [7:0]  shift_tx;
    logic [7:0]  shift_rx;
    logic        shift_done;
    logic [3:0]  dbg_state;

    // Sequencer side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  shift_rx, shift_done,
        output ack0, ack1, rdata, err, busy, cs_n, shift_start, shift_tx,
        output dbg_state
    );

    // Requesters plus shift engine side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output shift_rx, shift_done,
        input  ack0, ack1, rdata, err, busy, cs_n, shift_start, shift_tx,
        input  dbg_state
    );
endinterface

// File: rtl/spi_flash_sequencer.sv
// Two-port arbiter and SPI NOR flash transaction sequencer. Expands a 32-bit
// word read into a READ (0x03) frame, and a word write into WREN (0x06),
// PAGE PROGRAM (0x02) and repeated RDSR (0x05) busy-poll frames.
module spi_flash_sequencer #(
    parameter int CS_GAP   = 4,
    parameter int POLL_MAX = 1024
) (
    input logic                  clk,
    input logic                  rst_n,
    spi_flash_sequencer_if.slave bus
);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        WREN = 4'd1,
        GAP1 = 4'd2,
        CMD  = 4'd3,
        ADDR = 4'd4,
        DATA = 4'd5,
        GAP2 = 4'd6,
        POLL = 4'd7,
        GAP3 = 4'd8,
        ACK  = 4'd9
    } state_t;

    state_t         state_q, state_d;
    logic           port_q, port_d;     // granted port
    logic           last_q, last_d;     // port granted most recently
    logic           we_q, we_d;
    logic [23:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    word_q, word_d;     // read word being assembled
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
    logic           fin_q, fin_d;       // polling finished, next gap ends in ACK
    logic           perr_q, perr_d;     // pending timeout result
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           cs_n_q, cs_n_d;
    logic           shift_start_q, shift_start_d;
    logic [7:0]     shift_tx_q, shift_tx_d;

    logic           pick;
    logic           pick_we;
    logic           gap_done;
    logic [PW-1:0]  poll_inc;

    // Round-robin only matters on a tie: the port not served last wins.
    assign pick     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    assign pick_we  = pick ? bus.we1 : bus.we0;
    assign gap_done = (gap_cnt_q == GW'(CS_GAP - 1));
    assign poll_inc = poll_cnt_q + PW'(1);

    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] i);
        case (i)
            2'd0:    addr_byte = a[23:16];
            2'd1:    addr_byte = a[15:8];
            default: addr_byte = a[7:0];
        endcase
    endfunction

    function automatic logic [7:0] data_byte(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    data_byte = w[31:24];
            2'd1:    data_byte = w[23:16];
            2'd2:    data_byte = w[15:8];
            default: data_byte = w[7:0];
        endcase
    endfunction

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        last_d        = last_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        word_d        = word_q;
        byte_cnt_d    = byte_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        fin_d         = fin_q;
        perr_d        = perr_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata_d       = rdata_q;
        err_d         = err_q;
        busy_d        = busy_q;
        cs_n_d        = cs_n_q;
        shift_start_d = 1'b0;
        shift_tx_d    = shift_tx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    port_d        = pick;
                    last_d        = pick;
                    we_d          = pick_we;
                    addr_d        = pick ? bus.addr1 : bus.addr0;
                    wdata_d       = pick ? bus.wdata1 : bus.wdata0;
                    busy_d        = 1'b1;
                    cs_n_d        = 1'b0;
                    shift_start_d = 1'b1;
                    shift_tx_d    = pick_we ? 8'h06 : 8'h03;
                    state_d       = pick_we ? WREN : CMD;
                    byte_cnt_d    = 2'd0;
                    poll_cnt_d    = '0;
                    fin_d         = 1'b0;
                    perr_d        = 1'b0;
                end
            end
            WREN: begin
                if (bus.shift_done) begin
                    cs_n_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = GAP1;
                end
            end
            GAP1: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_done) begin
                    cs_n_d        = 1'b0;
                    shift_start_d = 1'b1;
                    shift_tx_d    = 8'h02;
                    state_d       = CMD;
                end
            end
            CMD: begin
                if (bus.shift_done) begin
                    shift_start_d = 1'b1;
                    shift_tx_d    = addr_byte(addr_q, 2'd0);
                    byte_cnt_d    = 2'd0;
                    state_d       = ADDR;
                end
            end
            ADDR: begin
                if (bus.shift_done) begin
                    shift_start_d = 1'b1;
                    if (byte_cnt_q == 2'd2) begin
                        shift_tx_d = we_q ? data_byte(wdata_q, 2'd0) : 8'h00;
                        byte_cnt_d = 2'd0;
                        state_d    = DATA;
                    end else begin
                        shift_tx_d = addr_byte(addr_q, byte_cnt_q + 2'd1);
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            DATA: begin
                if (bus.shift_done) begin
                    if (!we_q) begin
                        word_d = {word_q[23:0], bus.shift_rx};
                    end
                    if (byte_cnt_q == 2'd3) begin
                        cs_n_d    = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = GAP2;
                    end else begin
                        shift_start_d = 1'b1;
                        shift_tx_d    = we_q ? data_byte(wdata_q, byte_cnt_q + 2'd1) : 8'h00;
                        byte_cnt_d    = byte_cnt_q + 2'd1;
                    end
                end
            end
            GAP2: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_done) begin
                    if (we_q && !fin_q) begin
                        cs_n_d        = 1'b0;
                        shift_start_d = 1'b1;
                        shift_tx_d    = 8'h05;
                        byte_cnt_d    = 2'd0;
                        state_d       = POLL;
                    end else begin
                        ack0_d  = ~port_q;
                        ack1_d  = port_q;
                        err_d   = perr_q;
                        rdata_d = we_q ? rdata_q : word_q;
                        state_d = ACK;
                    end
                end
            end
            POLL: begin
                if (bus.shift_done) begin
                    if (byte_cnt_q == 2'd0) begin
                        shift_start_d = 1'b1;
                        shift_tx_d    = 8'h00;
                        byte_cnt_d    = 2'd1;
                    end else begin
                        cs_n_d     = 1'b1;
                        gap_cnt_d  = '0;
                        poll_cnt_d = poll_inc;
                        if (!bus.shift_rx[0]) begin
                            fin_d   = 1'b1;
                            perr_d  = 1'b0;
                            state_d = GAP2;
                        end else if (poll_inc >= PW'(POLL_MAX)) begin
                            fin_d   = 1'b1;
                            perr_d  = 1'b1;
                            state_d = GAP2;
                        end else begin
                            state_d = GAP3;
                        end
                    end
                end
            end
            GAP3: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_done) begin
                    cs_n_d        = 1'b0;
                    shift_start_d = 1'b1;
                    shift_tx_d    = 8'h05;
                    byte_cnt_d    = 2'd0;
                    state_d       = POLL;
                end
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces cs_n high without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            port_q        <= 1'b0;
            last_q        <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            word_q        <= '0;
            byte_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            poll_cnt_q    <= '0;
            fin_q         <= 1'b0;
            perr_q        <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            cs_n_q        <= 1'b1;
            shift_start_q <= 1'b0;
            shift_tx_q    <= '0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            last_q        <= last_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            word_q        <= word_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            poll_cnt_q    <= poll_cnt_d;
            fin_q         <= fin_d;
            perr_q        <= perr_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            cs_n_q        <= cs_n_d;
            shift_start_q <= shift_start_d;
            shift_tx_q    <= shift_tx_d;
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata       = rdata_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.cs_n        = cs_n_q;
    assign bus.shift_start = shift_start_q;
    assign bus.shift_tx    = shift_tx_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Bench for spi_flash_sequencer: directed transactions, a behavioural shift
// engine with configurable byte delay, and queue-based scoreboards for the
// transmitted byte stream and the ack responses.
module tb_spi_flash_sequencer;
    localparam int CS_GAP   = 4;
    localparam int POLL_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spi_flash_sequencer_if bus();

    spi_flash_sequencer #(
        .CS_GAP   (CS_GAP),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [49:0] exp_q[$];     // {latency(16, 0 = unchecked), port, err, rdata}
    logic [8:0]  exp_tx_q[$];  // {first byte of frame, byte}
    logic [7:0]  rx_q[$];      // bytes the engine returns, one per shift
    logic [31:0] model_rdata = 32'h0;
    int          eng_d = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected event expected none (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural shift engine ----------------
    int eng_cnt = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt        = 0;
            bus.shift_done = 1'b0;
            bus.shift_rx   = 8'h00;
        end else begin
            bus.shift_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.shift_done = 1'b1;
                    if (rx_q.size() > 0) bus.shift_rx = rx_q.pop_front();
                    else                 bus.shift_rx = 8'h00;
                end
            end
            if (bus.shift_start) eng_cnt = eng_d;
        end
    end

    // ---------------- monitor ----------------
    logic        cs_prev   = 1'b1;
    logic        busy_prev = 1'b0;
    int          rise_cyc  = 0;
    int          run_len   = 0;
    logic        run_busy  = 1'b0;
    logic [8:0]  tx_e;
    logic [49:0] ack_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.shift_start) begin
                chk("cs_low_on_start", 64'(bus.cs_n), 64'd0);
                if (exp_tx_q.size() == 0) fail_event("unexpected_tx_byte");
                else begin
                    tx_e = exp_tx_q.pop_front();
                    chk("tx_byte", 64'({cs_prev, bus.shift_tx}), 64'(tx_e));
                end
            end
            if (bus.cs_n) begin
                if (!cs_prev) begin
                    run_len  = 1;
                    run_busy = bus.busy;
                end else begin
                    run_len++;
                    run_busy = run_busy & bus.busy;
                end
            end else if (cs_prev && run_busy) begin
                chk("cs_gap", 64'(run_len), 64'(CS_GAP));
            end
            if (bus.busy && !busy_prev) rise_cyc = cyc;
            if (bus.ack0 || bus.ack1) begin
                if (exp_q.size() == 0) fail_event("unexpected_ack");
                else begin
                    ack_e = exp_q.pop_front();
                    chk("ack_port", 64'({bus.ack1, bus.ack0}), ack_e[33] ? 64'd2 : 64'd1);
                    chk("rdata", 64'(bus.rdata), 64'(ack_e[31:0]));
                    chk("err", 64'(bus.err), 64'(ack_e[32]));
                    if (ack_e[49:34] != 16'd0)
                        chk("latency", 64'(cyc - rise_cyc + 1), 64'(ack_e[49:34]));
                end
            end
            cs_prev   = bus.cs_n;
            busy_prev = bus.busy;
        end else begin
            cs_prev   = 1'b1;
            busy_prev = 1'b0;
            run_busy  = 1'b0;
        end
    end

    // ---------------- expectation builders ----------------
    task automatic push_tx(input logic first, input logic [7:0] b);
        exp_tx_q.push_back({first, b});
    endtask

    task automatic exp_read(input logic port, input logic [23:0] a, input logic [31:0] d);
        push_tx(1'b1, 8'h03);
        push_tx(1'b0, a[23:16]);
        push_tx(1'b0, a[15:8]);
        push_tx(1'b0, a[7:0]);
        repeat (4) push_tx(1'b0, 8'h00);
        repeat (4) rx_q.push_back(8'h00);
        rx_q.push_back(d[31:24]);
        rx_q.push_back(d[23:16]);
        rx_q.push_back(d[15:8]);
        rx_q.push_back(d[7:0]);
        model_rdata = d;
        exp_q.push_back({16'(8 * (eng_d + 1) + CS_GAP + 1), port, 1'b0, d});
    endtask

    task automatic exp_write(input logic port, input logic [23:0] a, input logic [31:0] w,
                             input int n_polls, input logic timeout, input logic [7:0] last_st);
        logic [7:0] st;
        push_tx(1'b1, 8'h06);
        rx_q.push_back(8'h00);
        push_tx(1'b1, 8'h02);
        push_tx(1'b0, a[23:16]);
        push_tx(1'b0, a[15:8]);
        push_tx(1'b0, a[7:0]);
        push_tx(1'b0, w[31:24]);
        push_tx(1'b0, w[23:16]);
        push_tx(1'b0, w[15:8]);
        push_tx(1'b0, w[7:0]);
        repeat (8) rx_q.push_back(8'h00);
        for (int i = 0; i < n_polls; i++) begin
            st = (timeout || i < n_polls - 1) ? 8'h01 : last_st;
            push_tx(1'b1, 8'h05);
            push_tx(1'b0, 8'h00);
            rx_q.push_back(8'h00);
            rx_q.push_back(st);
        end
        exp_q.push_back({16'd0, port, timeout, model_rdata});
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_port(input logic port, input logic we, input logic [23:0] a,
                            input logic [31:0] w);
        if (port) begin
            bus.we1 = we; bus.addr1 = a; bus.wdata1 = w; bus.req1 = 1'b1;
        end else begin
            bus.we0 = we; bus.addr0 = a; bus.wdata0 = w; bus.req0 = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((bus.req0 || bus.req1 || bus.busy) && n < budget) begin
            @(negedge clk);
            if (bus.ack0) bus.req0 = 1'b0;
            if (bus.ack1) bus.req1 = 1'b0;
            n++;
        end
        chk("done_in_budget", 64'(n < budget), 64'd1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic one(input logic port, input logic we, input logic [23:0] a,
                       input logic [31:0] w);
        @(posedge clk); #2;
        set_port(port, we, a, w);
        wait_done(2000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cs_n", 64'(bus.cs_n), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ack", 64'({bus.ack1, bus.ack0}), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_shift_start", 64'(bus.shift_start), 64'd0);
        chk("rst_shift_tx", 64'(bus.shift_tx), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Plain read on port 0
        exp_read(1'b0, 24'h012345, 32'hDEADBEEF);
        one(1'b0, 1'b0, 24'h012345, 32'h0);

        // Write on port 1 with three busy polls
        exp_write(1'b1, 24'h00FF00, 32'hCAFEF00D, 3, 1'b0, 8'h00);
        one(1'b1, 1'b1, 24'h00FF00, 32'hCAFEF00D);

        // Simultaneous requests: port 0 first, then port 1
        exp_read(1'b0, 24'h100000, 32'h01020304);
        exp_read(1'b1, 24'h200000, 32'hA5A55A5A);
        @(posedge clk); #2;
        set_port(1'b0, 1'b0, 24'h100000, 32'h0);
        set_port(1'b1, 1'b0, 24'h200000, 32'h0);
        wait_done(2000);

        // Second tie: port 0 write (status 0xFE counts as ready) then port 1 read
        exp_write(1'b0, 24'h300004, 32'h12345678, 1, 1'b0, 8'hFE);
        exp_read(1'b1, 24'h400008, 32'h0F0F0F0F);
        @(posedge clk); #2;
        set_port(1'b0, 1'b1, 24'h300004, 32'h12345678);
        set_port(1'b1, 1'b0, 24'h400008, 32'h0);
        wait_done(2000);

        // Port 0 served alone, so the next tie goes to port 1
        exp_read(1'b0, 24'hABCDEF, 32'h13579BDF);
        one(1'b0, 1'b0, 24'hABCDEF, 32'h0);
        exp_read(1'b1, 24'h000010, 32'h2468ACE0);
        exp_read(1'b0, 24'h000020, 32'h89ABCDEF);
        @(posedge clk); #2;
        set_port(1'b0, 1'b0, 24'h000020, 32'h0);
        set_port(1'b1, 1'b0, 24'h000010, 32'h0);
        wait_done(2000);

        // Status stuck busy: exactly POLL_MAX poll frames, then err
        exp_write(1'b1, 24'h0000AA, 32'h55AA55AA, POLL_MAX, 1'b1, 8'h01);
        one(1'b1, 1'b1, 24'h0000AA, 32'h55AA55AA);

        // Reset during the address phase of a read
        begin
            int n = 0;
            exp_read(1'b0, 24'h000100, 32'h11223344);
            @(posedge clk); #2;
            set_port(1'b0, 1'b0, 24'h000100, 32'h0);
            while (bus.dbg_state != 4'd4 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("reach_addr_phase", 64'(n < 200), 64'd1);
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            chk("abort_cs_n", 64'(bus.cs_n), 64'd1);
            chk("abort_busy", 64'(bus.busy), 64'd0);
            chk("abort_ack", 64'({bus.ack1, bus.ack0}), 64'd0);
            bus.req0 = 1'b0;
            exp_q.delete();
            exp_tx_q.delete();
            rx_q.delete();
            model_rdata = 32'h0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
        end

        // Fresh read after the abort
        exp_read(1'b0, 24'h000100, 32'h11223344);
        one(1'b0, 1'b0, 24'h000100, 32'h0);

        // Slower engine: three-cycle byte answer
        eng_d = 3;
        exp_read(1'b1, 24'h7E0001, 32'hFEEDC0DE);
        one(1'b1, 1'b0, 24'h7E0001, 32'h0);

        repeat (10) @(posedge clk);
        chk("ack_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("tx_queue_empty", 64'(exp_tx_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected completion (t=%0t)", $time);
        $fatal(1, "simulation time limit reached");
    end
endmodule
